// File: rtl/step_onehot_encoder_if.sv
// Bundles the step vector, error clear and encoder results for step_onehot_encoder.
// master drives the step vector; slave is the encoder side.
interface step_onehot_encoder_if #(
   parameter int NSTEPS = 11,
   parameter int CW     = 4,
   parameter int DONE_W = 8
);
   logic [0:NSTEPS-1] I;
   logic              clr_err;
   logic [CW-1:0]     count;
   logic              count_valid;
   logic              onehot_err;
   logic              seq_err;
   logic              err_sticky;
   logic [DONE_W-1:0] done_cnt;

   modport master (
      output I, clr_err,
      input  count, count_valid, onehot_err, seq_err, err_sticky, done_cnt
   );

   modport slave (
      input  I, clr_err,
      output count, count_valid, onehot_err, seq_err, err_sticky, done_cnt
   );
endinterface

// File: rtl/step_onehot_encoder.sv
// Run-time monitor beside the control unit: re-encodes the one-hot step vector to a
// registered step count, checks one-hot legality and step ordering, counts finished sequences.
module step_onehot_encoder #(
   parameter int NSTEPS = 11,
   parameter int CW     = 4,
   parameter int DONE_W = 8
) (
   input  logic               Clock,
   input  logic               Resetn,
   step_onehot_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_count,       w_count_nxt;
   logic              r_count_valid, w_count_valid_nxt;
   logic              r_onehot_err,  w_onehot_err_nxt;
   logic              r_seq_err,     w_seq_err_nxt;
   logic              r_err_sticky,  w_err_sticky_nxt;
   logic [DONE_W-1:0] r_done_cnt,    w_done_cnt_nxt;

   logic [CW-1:0]     w_k;
   logic              w_zero;
   logic              w_multi;
   logic              w_advance;

   // Classify the sampled vector: index of the set bit, empty, or more than one bit.
   always_comb begin
      w_k     = {CW{1'b0}};
      w_zero  = (bus.I == {NSTEPS{1'b0}});
      w_multi = ($countones(bus.I) > 1);
      for (int i = 0; i < NSTEPS; i++) begin
         w_k = bus.I[i] ? CW'(i) : w_k;
      end
      w_advance = (w_k == CW'(r_count + CW'(1))) && (r_count < CW'(NSTEPS - 1));
   end

   // Next-state and next-output logic; a detected error overrides clr_err on err_sticky.
   always_comb begin
      w_state_nxt       = r_state;
      w_count_nxt       = r_count;
      w_count_valid_nxt = 1'b0;
      w_onehot_err_nxt  = 1'b0;
      w_seq_err_nxt     = 1'b0;
      w_err_sticky_nxt  = bus.clr_err ? 1'b0 : r_err_sticky;
      w_done_cnt_nxt    = r_done_cnt;
      case (r_state)
         IDLE: begin
            if (w_multi) begin
               w_onehot_err_nxt = 1'b1;
               w_err_sticky_nxt = 1'b1;
            end else if (!w_zero && (w_k == {CW{1'b0}})) begin
               w_state_nxt       = TRACK;
               w_count_nxt       = {CW{1'b0}};
               w_count_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         TRACK: begin
            if (w_zero || w_multi) begin
               w_onehot_err_nxt = 1'b1;
               w_err_sticky_nxt = 1'b1;
               w_state_nxt      = FAULT;
            end else if (w_k == r_count) begin
               w_count_valid_nxt = 1'b1;
            end else if (w_advance) begin
               w_count_nxt       = w_k;
               w_count_valid_nxt = 1'b1;
            end else if (w_k == {CW{1'b0}}) begin
               // Both normal completion and early termination count as a finished sequence.
               w_count_nxt       = {CW{1'b0}};
               w_count_valid_nxt = 1'b1;
               w_done_cnt_nxt    = r_done_cnt + {{(DONE_W-1){1'b0}}, 1'b1};
            end else begin
               w_seq_err_nxt    = 1'b1;
               w_err_sticky_nxt = 1'b1;
               w_state_nxt      = FAULT;
            end
         end
         FAULT: begin
            if (bus.clr_err) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = FAULT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state       <= IDLE;
         r_count       <= {CW{1'b0}};
         r_count_valid <= 1'b0;
         r_onehot_err  <= 1'b0;
         r_seq_err     <= 1'b0;
         r_err_sticky  <= 1'b0;
         r_done_cnt    <= {DONE_W{1'b0}};
      end else begin
         r_state       <= w_state_nxt;
         r_count       <= w_count_nxt;
         r_count_valid <= w_count_valid_nxt;
         r_onehot_err  <= w_onehot_err_nxt;
         r_seq_err     <= w_seq_err_nxt;
         r_err_sticky  <= w_err_sticky_nxt;
         r_done_cnt    <= w_done_cnt_nxt;
      end
   end

   assign bus.count       = r_count;
   assign bus.count_valid = r_count_valid;
   assign bus.onehot_err  = r_onehot_err;
   assign bus.seq_err     = r_seq_err;
   assign bus.err_sticky  = r_err_sticky;
   assign bus.done_cnt    = r_done_cnt;

endmodule

// File: tb/tb_step_onehot_encoder.sv
// Self-checking bench for step_onehot_encoder: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the step rules.
module tb_step_onehot_encoder;

   logic Clock;
   logic Resetn;
   int   errors;
   int   checks;

   step_onehot_encoder_if #(.NSTEPS(11), .CW(4), .DONE_W(8)) bus ();

   step_onehot_encoder #(.NSTEPS(11), .CW(4), .DONE_W(8)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus.slave)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Behavioural model: mode 0=idle, 1=tracking, 2=faulted.
   int m_mode;
   int m_p;
   int m_done;
   bit m_valid;
   bit m_oh;
   bit m_seq;
   bit m_sticky;

   function automatic logic [0:10] oh(input int k);
      logic [0:10] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic model_step(input logic [0:10] iv, input bit clr, input bit rn);
      int ones;
      int k;
      ones  = $countones(iv);
      k     = -1;
      for (int i = 0; i < 11; i++) if (iv[i]) k = i;
      m_oh  = 0;
      m_seq = 0;
      if (!rn) begin
         m_mode = 0; m_p = 0; m_done = 0; m_valid = 0; m_sticky = 0;
         return;
      end
      if (clr) m_sticky = 0;
      if (m_mode == 0) begin
         m_valid = 0;
         if (ones > 1) begin
            m_oh = 1; m_sticky = 1;
         end else if (ones == 1 && k == 0) begin
            m_mode = 1; m_p = 0; m_valid = 1;
         end
      end else if (m_mode == 1) begin
         if (ones != 1) begin
            m_oh = 1; m_sticky = 1; m_mode = 2; m_valid = 0;
         end else if (k == m_p || k == m_p + 1) begin
            m_p = k;
         end else if (k == 0) begin
            m_p = 0; m_done = (m_done + 1) % 256;
         end else begin
            m_seq = 1; m_sticky = 1; m_mode = 2; m_valid = 0;
         end
      end else begin
         m_valid = 0;
         if (clr) m_mode = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, advance model at the edge, compare on the falling edge.
   task automatic cycle(input logic [0:10] iv, input bit clr, input bit rn);
      bus.I       = iv;
      bus.clr_err = clr;
      Resetn      = rn;
      @(posedge Clock);
      model_step(iv, clr, rn);
      @(negedge Clock);
      chk("count",       32'(bus.count),       32'(m_p));
      chk("count_valid", 32'(bus.count_valid), 32'(m_valid));
      chk("onehot_err",  32'(bus.onehot_err),  32'(m_oh));
      chk("seq_err",     32'(bus.seq_err),     32'(m_seq));
      chk("err_sticky",  32'(bus.err_sticky),  32'(m_sticky));
      chk("done_cnt",    32'(bus.done_cnt),    32'(m_done));
   endtask

   initial begin
      logic [0:10] v;
      int r;
      errors = 0;
      checks = 0;
      m_mode = 0; m_p = 0; m_done = 0;
      m_valid = 0; m_oh = 0; m_seq = 0; m_sticky = 0;
      bus.I = '0; bus.clr_err = 1'b0; Resetn = 1'b0;

      // Reset, then a full 0..10,0 sequence.
      cycle('0, 0, 0);
      cycle('0, 0, 0);
      for (int s = 0; s <= 10; s++) cycle(oh(s), 0, 1);
      cycle(oh(0), 0, 1);
      chk("full_seq_done", 32'(bus.done_cnt), 32'd1);

      // Hold at step 3 for four cycles, then advance.
      for (int s = 1; s <= 3; s++) cycle(oh(s), 0, 1);
      for (int n = 0; n < 3; n++) cycle(oh(3), 0, 1);
      cycle(oh(4), 0, 1);
      chk("hold_then_4", 32'(bus.count), 32'd4);

      // Illegal jump 2 -> 5, random input while faulted, clear, re-enter.
      cycle(oh(0), 0, 1);
      cycle(oh(1), 0, 1);
      cycle(oh(2), 0, 1);
      cycle(oh(5), 0, 1);
      chk("jump_seq_err", 32'(bus.seq_err), 32'd1);
      chk("jump_count",   32'(bus.count),   32'd2);
      for (int n = 0; n < 5; n++) cycle(11'($urandom), 0, 1);
      cycle('0, 1, 1);
      chk("clr_sticky", 32'(bus.err_sticky), 32'd0);
      cycle(oh(0), 0, 1);
      chk("reenter_valid", 32'(bus.count_valid), 32'd1);

      // Multi-hot while tracking, then zero vectors in idle.
      v = 11'b00110000000;
      cycle(v, 0, 1);
      chk("multi_oh_err", 32'(bus.onehot_err), 32'd1);
      cycle('0, 1, 1);
      for (int n = 0; n < 5; n++) cycle('0, 0, 1);
      chk("idle_zero_noerr", 32'(bus.err_sticky), 32'd0);

      // 256 early-terminating sequences wrap done_cnt back to zero.
      cycle('0, 0, 0);
      for (int n = 0; n < 256; n++) begin
         cycle(oh(0), 0, 1);
         cycle(oh(1), 0, 1);
         cycle(oh(2), 0, 1);
      end
      chk("done_255", 32'(bus.done_cnt), 32'd255);
      cycle(oh(0), 0, 1);
      chk("done_wrap", 32'(bus.done_cnt), 32'd0);
      cycle(oh(6), 1, 1);
      chk("err_beats_clr", 32'(bus.err_sticky), 32'd1);

      // Reset mid-sequence at step 7 with err_sticky set.
      cycle('0, 1, 1);
      cycle(11'b11000000000, 0, 1);
      for (int s = 0; s <= 7; s++) cycle(oh(s), 0, 1);
      chk("pre_reset_sticky", 32'(bus.err_sticky), 32'd1);
      cycle(oh(8), 0, 0);
      chk("reset_valid", 32'(bus.count_valid), 32'd0);
      cycle(oh(4), 0, 1);
      chk("ignored_4", 32'(bus.count_valid), 32'd0);
      cycle(oh(0), 0, 1);
      chk("restart_0", 32'(bus.count_valid), 32'd1);

      // Random stimulus biased toward legal progress.
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60)      v = oh((m_p < 10 && $urandom_range(0, 3) != 0) ? m_p + 1 : 0);
         else if (r < 72) v = oh(m_p);
         else if (r < 80) v = '0;
         else if (r < 88) v = oh(1 << $urandom_range(0, 3)) | oh(int'($urandom_range(0, 10)));
         else             v = oh(int'($urandom_range(0, 10)));
         cycle(v, $urandom_range(0, 15) == 0, $urandom_range(0, 299) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
